// File: rtl/spi_master_if.sv
// Host command/response handshake plus SPI pin bundle for spi_master.
// The master modport is the DUT side; the slave modport is the host/bus side.
interface spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       SS_n;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  cmd_valid, cmd_data, MISO,
    output cmd_ready, rd_valid, rd_data, busy, SS_n, SCLK, MOSI
  );

  modport slave (
    output cmd_valid, cmd_data, MISO,
    input  cmd_ready, rd_valid, rd_data, busy, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// SPI master for the 10-bit command frame protocol; opcode 11 frames clock in a byte from MISO.
// Optional build macro SPI_MASTER_CPOL1_EN: SCLK idles high and the active edge is falling.
module spi_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEAD = 3'd1;
  localparam logic [2:0] ST_TX   = 3'd2;
  localparam logic [2:0] ST_RX   = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

`ifdef SPI_MASTER_CPOL1_EN
  localparam logic SCLK_IDLE = 1'b1;
`else
  localparam logic SCLK_IDLE = 1'b0;
`endif
  localparam logic SCLK_ACT = ~SCLK_IDLE;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [8:0]    tx_sr_q, tx_sr_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic          rd_frame_q, rd_frame_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ss_n_q, ss_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          div_wrap;

  assign div_wrap = (div_cnt_q == DW'(CLK_DIV - 1));

  // bit_cnt counts SCLK half-periods: even = active half, odd = inactive half.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rd_frame_d = rd_frame_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ss_n_d     = ss_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = ST_LEAD;
          tx_sr_d    = bus.cmd_data[8:0];
          rd_frame_d = &bus.cmd_data[9:8];
          rx_sr_d    = '0;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          ss_n_d     = 1'b0;
          mosi_d     = bus.cmd_data[9];
        end
      end
      ST_LEAD: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
        if (div_wrap) begin
          state_d   = ST_TX;
          bit_cnt_d = '0;
          sclk_d    = SCLK_ACT;
        end
      end
      ST_TX: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
        if (div_wrap) begin
          if (bit_cnt_q == 5'd19) begin
            bit_cnt_d = '0;
            mosi_d    = 1'b0;
            if (rd_frame_q) begin
              // First RX active edge follows directly, so MISO is sampled here too.
              state_d = ST_RX;
              sclk_d  = SCLK_ACT;
              rx_sr_d = {bus.MISO, rx_sr_q[7:1]};
            end else begin
              state_d   = ST_GAP;
              sclk_d    = SCLK_IDLE;
              ss_n_d    = 1'b1;
              gap_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            sclk_d    = ~sclk_q;
            if (!bit_cnt_q[0]) begin
              mosi_d  = tx_sr_q[8];
              tx_sr_d = {tx_sr_q[7:0], 1'b0};
            end
          end
        end
      end
      ST_RX: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
        if (div_wrap) begin
          if (bit_cnt_q == 5'd15) begin
            state_d    = ST_GAP;
            bit_cnt_d  = '0;
            sclk_d     = SCLK_IDLE;
            ss_n_d     = 1'b1;
            gap_cnt_d  = '0;
            rd_valid_d = 1'b1;
            rd_data_d  = rx_sr_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            sclk_d    = ~sclk_q;
            if (bit_cnt_q[0]) rx_sr_d = {bus.MISO, rx_sr_q[7:1]};
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(CS_GAP - 1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rd_frame_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rd_frame_q <= rd_frame_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.SS_n      = ss_n_q;
  assign bus.SCLK      = sclk_q;
  assign bus.MOSI      = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: one instance at CLK_DIV=2/CS_GAP=2, one at CLK_DIV=1/CS_GAP=1.
// A negedge monitor plays the SPI slave and records what it sees on the bus.
module tb_spi_master;
  localparam int DIV0 = 2, GAP0 = 2, DIV1 = 1, GAP1 = 1;
`ifdef SPI_MASTER_CPOL1_EN
  localparam logic SCLK_IDLE = 1'b1;
`else
  localparam logic SCLK_IDLE = 1'b0;
`endif

  typedef struct {
    logic       sel;
    logic [9:0] cmd;
    logic [7:0] miso;
    int         exp_ss_low;
    int         exp_rv;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       miso = 1'b0;
  logic [7:0] slave_byte = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  spi_master_if if0 ();
  spi_master_if if1 ();

  spi_master #(.CLK_DIV(DIV0), .CS_GAP(GAP0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  spi_master #(.CLK_DIV(DIV1), .CS_GAP(GAP1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.master));

  assign if0.cmd_valid = cmd_valid && !sel;
  assign if1.cmd_valid = cmd_valid && sel;
  assign if0.cmd_data  = cmd_data;
  assign if1.cmd_data  = cmd_data;
  assign if0.MISO      = miso;
  assign if1.MISO      = miso;

  logic       o_ss_n, o_sclk, o_mosi, o_busy, o_ready, o_rv;
  logic [7:0] o_rd;
  assign o_ss_n  = sel ? if1.SS_n      : if0.SS_n;
  assign o_sclk  = sel ? if1.SCLK      : if0.SCLK;
  assign o_mosi  = sel ? if1.MOSI      : if0.MOSI;
  assign o_busy  = sel ? if1.busy      : if0.busy;
  assign o_ready = sel ? if1.cmd_ready : if0.cmd_ready;
  assign o_rv    = sel ? if1.rd_valid  : if0.rd_valid;
  assign o_rd    = sel ? if1.rd_data   : if0.rd_data;

  // Bus monitor + slave model
  int         cyc = 0, ss_low = 0, rv_cnt = 0, acc_cnt = 0, acc_cyc = 0, ss_rise_cyc = 0;
  int         idle_viol = 0, mosi_unstable = 0, done_nbits = 0, done_ss_low = 0;
  logic [9:0] done_word = '0;
  logic       done_tail = 1'b0;
  logic       prev_ss = 1'b1, prev_sclk = SCLK_IDLE, prev_mosi = 1'b0;
  logic       mosi_q[$];

  always @(negedge clk) begin
    int k;
    cyc++;
    if (prev_ss && !o_ss_n) begin
      mosi_q.delete();
      ss_low = 0;
      rv_cnt = 0;
      miso   = 1'($urandom);
    end
    if (!o_ss_n) begin
      ss_low++;
      if (prev_sclk == SCLK_IDLE && o_sclk != SCLK_IDLE) begin
        mosi_q.push_back(o_mosi);
        if (o_mosi != prev_mosi) mosi_unstable++;
      end
      k = mosi_q.size() - 10;
      if (prev_sclk != SCLK_IDLE && o_sclk == SCLK_IDLE && k >= 0 && k < 8) miso = slave_byte[k];
    end else if (o_sclk != SCLK_IDLE || o_mosi) begin
      idle_viol++;
    end
    if (!prev_ss && o_ss_n) begin
      ss_rise_cyc = cyc;
      done_ss_low = ss_low;
      done_nbits  = mosi_q.size();
      done_word   = '0;
      done_tail   = 1'b0;
      foreach (mosi_q[i]) begin
        if (i < 10) done_word = {done_word[8:0], mosi_q[i]};
        else        done_tail = done_tail | mosi_q[i];
      end
    end
    if (o_rv) rv_cnt++;
    if (cmd_valid && o_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    prev_ss   = o_ss_n;
    prev_sclk = o_sclk;
    prev_mosi = o_mosi;
  end

  logic [7:0] last_rd [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int to = 0;
    while (!o_ready && to < 500) begin
      tick();
      to++;
    end
    check({tag, "_ready_wait"}, 32'(to < 500), 1);
  endtask

  task automatic wait_idle(input string tag);
    int to = 0;
    while (o_busy && to < 500) begin
      tick();
      to++;
    end
    check({tag, "_done_wait"}, 32'(to < 500), 1);
  endtask

  task automatic run_frame(input logic s, input logic [9:0] cmd, input logic [7:0] mb,
                           input int exp_ss, input int exp_rv, input string tag);
    sel        = s;
    slave_byte = mb;
    tick();
    wait_ready(tag);
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_idle(tag);
    if (exp_rv != 0) last_rd[s] = mb;
    check({tag, "_mosi"},    32'(done_word),   32'(cmd));
    check({tag, "_nbits"},   done_nbits,       (exp_rv != 0) ? 18 : 10);
    check({tag, "_rx_mosi"}, 32'(done_tail),   0);
    check({tag, "_ss_low"},  done_ss_low,      exp_ss);
    check({tag, "_rv_cnt"},  rv_cnt,           exp_rv);
    check({tag, "_rd_data"}, 32'(o_rd),        32'(last_rd[s]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic       s;
    logic [9:0] c;
    logic [7:0] mb;
    int         acc0;
    int         to;

    vecs[0] = '{1'b0, 10'h0A5, 8'h00, 42, 0};
    vecs[1] = '{1'b0, 10'h3FF, 8'hC3, 74, 1};
    vecs[2] = '{1'b1, 10'h2AA, 8'h00, 21, 0};
    vecs[3] = '{1'b1, 10'h3FF, 8'hC3, 37, 1};
    vecs[4] = '{1'b0, 10'h1FF, 8'h00, 42, 0};
    vecs[5] = '{1'b0, 10'h200, 8'hFF, 42, 0};
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ss_n",     32'(o_ss_n),    1);
    check("rst_sclk",     32'(o_sclk),    32'(SCLK_IDLE));
    check("rst_mosi",     32'(o_mosi),    0);
    check("rst_busy",     32'(o_busy),    0);
    check("rst_rd_valid", 32'(o_rv),      0);
    check("rst_rd_data",  32'(o_rd),      0);
    check("rst_ready",    32'(o_ready),   0);
    check("rst_ss_n_d1",  32'(if1.SS_n),  1);
    check("rst_sclk_d1",  32'(if1.SCLK),  32'(SCLK_IDLE));
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(o_ready), 1);

    // Directed table
    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].sel, vecs[i].cmd, vecs[i].miso, vecs[i].exp_ss_low, vecs[i].exp_rv,
                $sformatf("vec%0d", i));

    // Back-to-back with cmd_valid held high and wiggled while busy
    sel        = 1'b0;
    slave_byte = 8'hC3;
    tick();
    wait_ready("b2b");
    acc0      = acc_cnt;
    cmd_data  = 10'h100;
    cmd_valid = 1'b1;
    tick();
    cmd_data = 10'h3FF;
    for (int i = 0; i < 30; i++) begin
      cmd_valid = i[0];
      tick();
    end
    cmd_valid = 1'b1;
    to = 0;
    while (acc_cnt < acc0 + 2 && to < 500) begin
      tick();
      to++;
    end
    cmd_valid = 1'b0;
    check("b2b_second_accept_wait", 32'(to < 500), 1);
    check("b2b_accept_gap",   acc_cyc - ss_rise_cyc, GAP0);
    check("b2b_first_mosi",   32'(done_word), 32'h100);
    check("b2b_first_ss_low", done_ss_low, 42);
    wait_idle("b2b");
    last_rd[0] = 8'hC3;
    check("b2b_second_mosi",   32'(done_word), 32'h3FF);
    check("b2b_second_ss_low", done_ss_low, 74);
    check("b2b_rv_cnt",        rv_cnt, 1);
    check("b2b_rd_data",       32'(o_rd), 32'hC3);
    check("b2b_accepts",       acc_cnt - acc0, 2);

    // Reset in the middle of the 5th TX bit of a read frame
    sel        = 1'b0;
    slave_byte = 8'h5A;
    tick();
    wait_ready("mid_rst");
    cmd_data  = 10'h3FF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    to = 0;
    while (mosi_q.size() < 5 && to < 500) begin
      tick();
      to++;
    end
    check("mid_rst_reach_bit5", 32'(to < 500), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_ss_n",     32'(o_ss_n),  1);
    check("mid_rst_sclk",     32'(o_sclk),  32'(SCLK_IDLE));
    check("mid_rst_mosi",     32'(o_mosi),  0);
    check("mid_rst_busy",     32'(o_busy),  0);
    check("mid_rst_rd_valid", 32'(o_rv),    0);
    check("mid_rst_rd_data",  32'(o_rd),    0);
    check("mid_rst_ready",    32'(o_ready), 0);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    tick();
    check("mid_rst_ready_after", 32'(o_ready), 1);
    check("mid_rst_no_rv",       rv_cnt, 0);

    // Randomized frames against the frame-level reference model
    for (int i = 0; i < 16; i++) begin
      s  = 1'($urandom_range(0, 1));
      c  = 10'($urandom);
      mb = 8'($urandom);
      run_frame(s, c, mb, ((&c[9:8]) ? 37 : 21) * (s ? DIV1 : DIV0), (&c[9:8]) ? 1 : 0,
                $sformatf("rnd%0d", i));
    end

    check("mosi_stable_at_active_edge", mosi_unstable, 0);
    check("idle_lines_quiet",           idle_viol,     0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
